// File: rtl/branch_flag_gen.sv
// Multi-cycle branch comparator: compares a and b STEP bits per cycle, MSB chunk first,
// and produces zero/slt/sltu. Define BRANCH_FLAG_EARLY_EXIT_EN to stop at the first differing chunk.
module branch_flag_gen #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            valid,
    output logic            zero,
    output logic            slt,
    output logic            sltu
);

    localparam int N  = XLEN / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            diff_q, diff_d;
    logic            lt_q, lt_d;
    logic            zero_q, zero_d;
    logic            slt_q, slt_d;
    logic            sltu_q, sltu_d;

    logic [STEP-1:0] a_chunk;
    logic [STEP-1:0] b_chunk;
    logic            diff_now;
    logic            lt_now;
    logic            last_chunk;
    logic            sign_differs;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        lt_d    = lt_q;
        zero_d  = zero_q;
        slt_d   = slt_q;
        sltu_d  = sltu_q;

        a_chunk      = a_q[cnt_q*STEP +: STEP];
        b_chunk      = b_q[cnt_q*STEP +: STEP];
        // Once a difference is seen the unsigned verdict is frozen; lower chunks cannot overturn it.
        diff_now     = diff_q | (a_chunk != b_chunk);
        lt_now       = diff_q ? lt_q : (a_chunk < b_chunk);
        sign_differs = a_q[XLEN-1] ^ b_q[XLEN-1];
        last_chunk   = (cnt_q == '0);
`ifdef BRANCH_FLAG_EARLY_EXIT_EN
        last_chunk   = last_chunk | diff_now;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = CNT_INIT;
                    diff_d  = 1'b0;
                    lt_d    = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d = diff_now;
                lt_d   = lt_now;
                if (last_chunk) begin
                    zero_d  = ~diff_now;
                    sltu_d  = diff_now & lt_now;
                    slt_d   = sign_differs ? a_q[XLEN-1] : (diff_now & lt_now);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            diff_q  <= 1'b0;
            lt_q    <= 1'b0;
            zero_q  <= 1'b0;
            slt_q   <= 1'b0;
            sltu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            lt_q    <= lt_d;
            zero_q  <= zero_d;
            slt_q   <= slt_d;
            sltu_q  <= sltu_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign valid = (state_q == DONE);
    assign zero  = zero_q;
    assign slt   = slt_q;
    assign sltu  = sltu_q;

endmodule

// File: tb/tb_branch_flag_gen.sv
// Scoreboard bench for branch_flag_gen: driver pushes expected results/timing, negedge monitor checks.
module tb_branch_flag_gen;

    localparam int XLEN = 32;
    localparam int STEP = 4;
    localparam int N    = XLEN / STEP;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [XLEN-1:0] a, b;
    logic            busy, valid, zero, slt, sltu;

    branch_flag_gen #(.XLEN(XLEN), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .valid(valid), .zero(zero), .slt(slt), .sltu(sltu)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   start_cyc;
        int   due;
        logic z;
        logic s;
        logic su;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic hold_z, hold_s, hold_su;
    logic bexp, vexp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    function automatic int first_diff(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        for (int k = 1; k <= N; k++) begin
            if (((x >> ((N - k) * STEP)) % (1 << STEP)) != ((y >> ((N - k) * STEP)) % (1 << STEP)))
                return k;
        end
        return 0;
    endfunction

    function automatic int latency(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
`ifdef BRANCH_FLAG_EARLY_EXIT_EN
        if (x != y) return first_diff(x, y) + 1;
`endif
        return N + 1;
    endfunction

    // Issues one operation; returns in the last RUN cycle so a following call lands in DONE.
    task automatic run_op(input logic [XLEN-1:0] ai, input logic [XLEN-1:0] bi, input bit junk);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        a = ai;
        b = bi;
        e.start_cyc = cyc;
        e.due = cyc + latency(ai, bi);
        e.z  = (ai == bi);
        e.su = (ai < bi);
        e.s  = ($signed(ai) < $signed(bi));
        q.push_back(e);
        while (cyc < e.due - 1) begin
            @(posedge clk); #1;
            if (junk) begin
                start = 1'($urandom);
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bexp = (q.size() > 0) && (cyc > q[0].start_cyc) && (cyc < q[0].due);
            vexp = (q.size() > 0) && (cyc == q[0].due);
            check("busy", 32'(busy), 32'(bexp));
            check("valid", 32'(valid), 32'(vexp));
            if (vexp) begin
                hold_z  = q[0].z;
                hold_s  = q[0].s;
                hold_su = q[0].su;
                void'(q.pop_front());
            end
            check("zero", 32'(zero), 32'(hold_z));
            check("slt", 32'(slt), 32'(hold_s));
            check("sltu", 32'(sltu), 32'(hold_su));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XLEN-1:0] ra, rb;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        hold_z = 1'b0;
        hold_s = 1'b0;
        hold_su = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        run_op(32'h0000_0005, 32'h0000_0005, 1'b0);
        idle(2);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        idle(1);
        run_op(32'h0000_0001, 32'h8000_0000, 1'b0);
        idle(2);
        run_op(32'd3, 32'd7, 1'b1);
        idle(1);

        // reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; a = 32'd12; b = 32'd12;
        q.push_back('{start_cyc: cyc, due: cyc + N + 1, z: 1'b1, s: 1'b0, su: 1'b0});
        idle(3);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        q.delete();
        hold_z = 1'b0;
        hold_s = 1'b0;
        hold_su = 1'b0;
        run_op(32'h1234_5678, 32'h1234_5679, 1'b0);

        // back-to-back through DONE
        run_op(32'h8000_0000, 32'h0000_0000, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, XLEN - 1));
                2: rb = {ra[XLEN-1:16], 16'($urandom)};
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) run_op(ra, rb, 1'($urandom));
            else                           run_op(rb, ra, 1'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(N + 4);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
